aes_cipher_rx_buffer: RTL and testbench
=======================================

# aes_cipher_rx_buffer

Output-side companion of `aes_sbox_stream_cipher`. It captures every byte the cipher presents on `txt_out_char` while `dout_ready` is high, buffers the bytes in a FIFO, and re-issues them on a valid/ready stream toward the file sink or host. It also reports stream boundaries, overflow and byte counts, so the producer side of the cipher can be checked in hardware rather than only in the bench.

## Interface
Parameters:
- `DEPTH`, default 16: FIFO entries; must be a power of 2, minimum 2.
- `CNT_W`, default 16: width of the captured-byte counter.

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `dout_ready`  in  1  cipher output strobe; the byte is valid while high.
- `txt_out_char`  in  8  cipher output byte.
- `flush`  in  1  synchronous clear of FIFO, flags and counter.
- `m_valid`  out  1  downstream byte available.
- `m_data`  out  8  downstream byte.
- `m_ready`  in  1  downstream accept.
- `fill_level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `busy`  out  1  high when the FSM is not in IDLE.
- `eos`  out  1  one-cycle end-of-stream pulse.
- `overflow`  out  1  sticky; set when a byte is dropped.
- `byte_count`  out  CNT_W  bytes captured since reset or flush; saturating.
- `nonascii`  out  1  sticky non-ASCII flag; see Configuration.

## Operation
- **Push:** the block pushes on every rising edge where `dout_ready`=1. The cipher has no backpressure, so capture is never stalled.
- **Pop:** a pop occurs when `m_valid`=1 and `m_ready`=1. The FIFO is first-word-fall-through: `m_data` is the head entry whenever `m_valid`=1, and `m_valid` = (`fill_level` != 0).
- **Full with simultaneous pop:** the push is accepted and `fill_level` is unchanged.
- **Full without pop:** the byte is dropped, `overflow` is set, and `byte_count` still increments, because it counts captures, not stores.
- **Pointers:** read and write pointers have width $clog2(DEPTH) and wrap modulo DEPTH.
- **Push and pop on an empty FIFO:** the pop is not possible because `m_valid`=0. The byte is stored and `fill_level` becomes 1.
- **`byte_count` saturation:** it saturates at 2^CNT_W−1 and does not wrap.
- **`flush`:** has priority over push and pop in the same cycle. It empties the FIFO, clears `overflow`, `nonascii` and `byte_count`, and forces the FSM to IDLE. A byte presented in a flush cycle is discarded.
- **FSM:**
  - IDLE → ACTIVE when `dout_ready`=1.
  - ACTIVE → DRAIN when `dout_ready`=0. `eos` pulses for exactly one cycle on the cycle after the falling edge of `dout_ready` is sampled.
  - DRAIN → ACTIVE when `dout_ready`=1. A new stream starts and no `eos` is issued.
  - DRAIN → IDLE when `fill_level`=0 and `dout_ready`=0.
  - `busy` = (state != IDLE).

## Timing
- **Reset values:** `m_valid`=0, `m_data`=8'h00, `fill_level`=0, `busy`=0, `eos`=0, `overflow`=0, `byte_count`=0, `nonascii`=0; FSM in IDLE.
- **Capture latency:** a byte sampled at edge N appears on `m_data` with `m_valid`=1 after edge N, i.e. one cycle, when the FIFO was empty.
- **Sustained throughput:** 1 byte/cycle in and out.
- **Flag and counter timing:** `overflow`, `nonascii` and `byte_count` update on the same edge as the capture.
- **Reset mid-stream:** all state is cleared immediately. Partial data is lost and no `eos` is issued.
- **`eos` vs data:** `eos` does not wait for the FIFO to drain; `busy` falls only after the drain completes.

## Configuration
- `AES_RX_ASCII_CHECK_EN` defined: any captured byte outside 8'h01..8'h7F sets the sticky `nonascii` flag. The byte is still stored unchanged.
- `AES_RX_ASCII_CHECK_EN` undefined: `nonascii` is tied to 0 and no checking logic is built.

## Test plan
- **Basic stream:** `dout_ready` high for 5 cycles with bytes 8'h48,8'h65,8'h6C,8'h6C,8'h6F and `m_ready`=1 → same 5 bytes out in order, each one cycle after capture; `byte_count`=5; `eos` pulses once; `busy` falls after the drain.
- **Overflow:** DEPTH=16, `m_ready`=0, 18 bytes pushed → `fill_level`=16, `overflow`=1, `byte_count`=18. Then `m_ready`=1 → exactly the first 16 bytes emitted.
- **Full with simultaneous pop:** FIFO full, push 8'hAA with `m_ready`=1 → `fill_level` stays 16, no overflow, 8'hAA emitted last.
- **Flush priority:** `flush`=1 while `dout_ready`=1 with `fill_level`=7 and `overflow`=1 → next cycle `fill_level`=0, `overflow`=0, `byte_count`=0, FSM in IDLE, and the byte is discarded.
- **ASCII check:** with `AES_RX_ASCII_CHECK_EN`, push 8'h41 then 8'h80 → `nonascii` rises on the edge capturing 8'h80 and both bytes are output. Without the macro, `nonascii` stays 0.
- **Async reset mid-stream:** assert `rst_n`=0 mid-stream at 3.2 ns after a clock edge → all outputs reach their reset values before the next edge, and no `eos` is issued.

Source files
------------

// File: rtl/aes_cipher_rx_buffer.sv
// Capture buffer behind aes_sbox_stream_cipher: FWFT FIFO with valid/ready output,
// stream-boundary FSM, overflow/byte counters. Optional ASCII check via AES_RX_ASCII_CHECK_EN.
`timescale 1ns/1ps
module aes_cipher_rx_buffer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dout_ready,
  input  logic [7:0]               txt_out_char,
  input  logic                     flush,
  output logic                     m_valid,
  output logic [7:0]               m_data,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     busy,
  output logic                     eos,
  output logic                     overflow,
  output logic [CNT_W-1:0]         byte_count,
  output logic                     nonascii
);
  // state   | meaning
  // IDLE    | no stream seen, FIFO drained
  // ACTIVE  | cipher is presenting bytes
  // DRAIN   | stream ended, waiting for FIFO to empty
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    state, state_nxt;
  logic          push, pop, store, full;

  assign full  = (count == FULL_LVL);
  assign push  = dout_ready && !flush;
  assign pop   = m_valid && m_ready && !flush;
  // a full FIFO still takes the byte when the head leaves in the same cycle
  assign store = push && (!full || pop);

  assign m_valid    = (count != '0);
  assign m_data     = m_valid ? mem[rd_ptr] : 8'h00;
  assign fill_level = count;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= txt_out_char;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      byte_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      byte_count <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !store) overflow <= 1'b1;
      if (push && byte_count != CNT_MAX) byte_count <= byte_count + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (dout_ready) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (!dout_ready) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (dout_ready)         state_nxt = ST_ACTIVE;
        else if (count == '0)   state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      eos   <= 1'b0;
    end else if (flush) begin
      state <= ST_IDLE;
      eos   <= 1'b0;
    end else begin
      state <= state_nxt;
      eos   <= (state == ST_ACTIVE) && !dout_ready;
    end
  end

`ifdef AES_RX_ASCII_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           nonascii <= 1'b0;
    else if (flush)                                       nonascii <= 1'b0;
    else if (push && (txt_out_char == 8'h00 || txt_out_char[7])) nonascii <= 1'b1;
  end
`else
  assign nonascii = 1'b0;
`endif

endmodule

// File: tb/tb_aes_cipher_rx_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_aes_cipher_rx_buffer;
  localparam int DEPTH = 16;
  localparam int CNT_W = 6;
  localparam int CMAX  = 63;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dout_ready = 1'b0;
  logic [7:0] txt_out_char = 8'h00;
  logic       flush = 1'b0;
  logic       m_ready = 1'b0;
  logic       m_valid;
  logic [7:0] m_data;
  logic [4:0] fill_level;
  logic       busy, eos, overflow, nonascii;
  logic [CNT_W-1:0] byte_count;

  aes_cipher_rx_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .dout_ready(dout_ready), .txt_out_char(txt_out_char),
    .flush(flush), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .fill_level(fill_level), .busy(busy), .eos(eos), .overflow(overflow),
    .byte_count(byte_count), .nonascii(nonascii)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: plain queue plus stream bookkeeping
  logic [7:0] q[$];
  int cnt_m;
  bit ovf_m, na_m, eos_m, busy_m, streaming_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cnt_m = 0; ovf_m = 0; na_m = 0; eos_m = 0; busy_m = 0; streaming_m = 0;
  endtask

  task automatic model_edge(input bit dr, input logic [7:0] ch, input bit fl, input bit mr);
    int pre;
    bit popped;
    if (fl) begin
      model_reset();
      return;
    end
    pre    = q.size();
    popped = (pre > 0) && mr;
    eos_m  = streaming_m && !dr;
    if (popped) void'(q.pop_front());
    if (dr) begin
      if (pre < DEPTH || popped) q.push_back(ch);
      else ovf_m = 1;
      if (cnt_m < CMAX) cnt_m++;
`ifdef AES_RX_ASCII_CHECK_EN
      if (ch == 8'h00 || ch >= 8'h80) na_m = 1;
`endif
      busy_m = 1;
      streaming_m = 1;
    end else begin
      if (busy_m && !streaming_m && pre == 0) busy_m = 0;
      streaming_m = 0;
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".m_valid"},    m_valid,    q.size() != 0);
    chk({ph, ".m_data"},     m_data,     (q.size() != 0) ? q[0] : 8'h00);
    chk({ph, ".fill_level"}, fill_level, q.size());
    chk({ph, ".busy"},       busy,       busy_m);
    chk({ph, ".eos"},        eos,        eos_m);
    chk({ph, ".overflow"},   overflow,   ovf_m);
    chk({ph, ".byte_count"}, byte_count, cnt_m);
    chk({ph, ".nonascii"},   nonascii,   na_m);
  endtask

  task automatic step(input string ph, input bit dr, input logic [7:0] ch, input bit fl, input bit mr);
    dout_ready = dr; txt_out_char = ch; flush = fl; m_ready = mr;
    @(posedge clk);
    model_edge(dr, ch, fl, mr);
    #1;
    check_all(ph);
  endtask

  logic [7:0] hello [5];
  int eos_seen;

  initial begin
    hello[0] = 8'h48; hello[1] = 8'h65; hello[2] = 8'h6C; hello[3] = 8'h6C; hello[4] = 8'h6F;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("post_reset");

    // basic stream
    eos_seen = 0;
    for (int i = 0; i < 5; i++) step("basic", 1, hello[i], 0, 1);
    chk("basic.count5", byte_count, 5);
    for (int i = 0; i < 6; i++) begin
      step("basic_tail", 0, 8'h00, 0, 1);
      if (eos) eos_seen++;
    end
    chk("basic.eos_once", eos_seen, 1);
    chk("basic.idle", busy, 0);

    // overflow: 18 pushes, no pops, then drain
    step("flush0", 0, 8'h00, 1, 0);
    for (int i = 0; i < 18; i++) step("ovf", 1, 8'(8'h10 + i), 0, 0);
    chk("ovf.fill", fill_level, 16);
    chk("ovf.flag", overflow, 1);
    chk("ovf.count", byte_count, 18);
    for (int i = 0; i < 18; i++) step("ovf_drain", 0, 8'h00, 0, 1);

    // full with simultaneous pop
    step("flush1", 0, 8'h00, 1, 0);
    for (int i = 0; i < 16; i++) step("fill", 1, 8'(8'h20 + i), 0, 0);
    step("full_pop", 1, 8'hAA, 0, 1);
    chk("full_pop.fill", fill_level, 16);
    chk("full_pop.ovf", overflow, 0);
    for (int i = 0; i < 17; i++) step("full_pop_drain", 0, 8'h00, 0, 1);

    // flush priority with fill 7 and overflow set
    for (int i = 0; i < 17; i++) step("fl_fill", 1, 8'(8'h30 + i), 0, 0);
    for (int i = 0; i < 9; i++) step("fl_pop", 0, 8'h00, 0, 1);
    chk("fl.pre_fill", fill_level, 7);
    step("flush_pri", 1, 8'h55, 1, 1);
    chk("fl.fill", fill_level, 0);
    chk("fl.ovf", overflow, 0);
    chk("fl.busy", busy, 0);

    // ascii check
    step("ascii", 1, 8'h41, 0, 1);
    step("ascii", 1, 8'h80, 0, 1);
    for (int i = 0; i < 4; i++) step("ascii_tail", 0, 8'h00, 0, 1);

    // async reset mid-stream, 3.2 ns after an edge
    for (int i = 0; i < 4; i++) step("pre_rst", 1, 8'(8'h61 + i), 0, 0);
    #2.2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("post_rst", 0, 8'h00, 0, 1);

    // random traffic, bursty phases
    for (int ph = 0; ph < 40; ph++) begin
      int pdr, pmr;
      pdr = $urandom_range(0, 100);
      pmr = $urandom_range(0, 100);
      for (int i = 0; i < 100; i++) begin
        logic [7:0] ch;
        ch = 8'($urandom);
        if ($urandom_range(0, 9) == 0) ch = 8'h00;
        step("rand", $urandom_range(0, 99) < pdr, ch,
             $urandom_range(0, 499) == 0, $urandom_range(0, 99) < pmr);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
